// File: rtl/led_step_tick_gen.sv
// led_step_tick_gen: conditions the s0/s1/pause switches (2-flop sync + debounce),
// decodes the ring direction and emits a one-clk step pulse every (max+1) base ticks.
// Build option: define PAUSE_TOGGLE_EN to make pause_raw a push-to-toggle button
// instead of a level switch.
module led_step_tick_gen #(
  parameter int unsigned PRESCALE  = 1_000_000,
  parameter int unsigned DB_CYCLES = 500_000,
  parameter int unsigned MAX_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s0_raw,
  input  logic             s1_raw,
  input  logic             pause_raw,
  input  logic [MAX_W-1:0] max,
  output logic             step,
  output logic             fwd,
  output logic             rev,
  output logic             home,
  output logic             paused
);

  localparam int unsigned N_IN   = 3;
  localparam int unsigned IDX_S0 = 0;
  localparam int unsigned IDX_S1 = 1;
  localparam int unsigned IDX_PS = 2;
  localparam int unsigned PCNT_W = $clog2(PRESCALE);
  localparam int unsigned DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);

  logic [N_IN-1:0]           r_sync0;
  logic [N_IN-1:0]           r_sync1;
  logic [N_IN-1:0]           r_deb;
  logic [N_IN-1:0][DB_W-1:0] r_db_cnt;
  logic [PCNT_W-1:0]         r_pcnt;
  logic [MAX_W-1:0]          r_qcnt;

  logic w_fwd_nxt;
  logic w_rev_nxt;
  logic w_home_nxt;
  logic w_mode_chg;
  logic w_run;
  logic w_tick;
  logic w_paused_nxt;

  // Synchronise raw inputs and accept a new level only after DB_CYCLES equal samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync0  <= '0;
      r_sync1  <= '0;
      r_deb    <= '0;
      r_db_cnt <= '0;
    end else begin
      r_sync0 <= {pause_raw, s1_raw, s0_raw};
      r_sync1 <= r_sync0;
      for (int i = 0; i < int'(N_IN); i++) begin
        if (r_sync1[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_deb[i]    <= r_sync1[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Direction decode, mode-change detect and base-tick qualification
  always_comb begin
    w_fwd_nxt = 1'b0;
    w_rev_nxt = 1'b0;
    case ({r_deb[IDX_S1], r_deb[IDX_S0]})
      2'b10:   w_fwd_nxt = 1'b1;
      2'b01:   w_rev_nxt = 1'b1;
      default: ;
    endcase
    w_home_nxt = ~(w_fwd_nxt | w_rev_nxt);
    w_mode_chg = ({w_fwd_nxt, w_rev_nxt, w_home_nxt} != {fwd, rev, home});
    w_run      = ~paused & ~home;
    w_tick     = w_run & (r_pcnt == PCNT_LAST);
  end

`ifdef PAUSE_TOGGLE_EN
  logic r_pause_deb_q;

  // Remember last debounced pause level for rising-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pause_deb_q <= 1'b0;
    end else begin
      r_pause_deb_q <= r_deb[IDX_PS];
    end
  end

  // Each debounced press flips the pause state
  always_comb begin
    w_paused_nxt = paused;
    if (r_deb[IDX_PS] && !r_pause_deb_q) begin
      w_paused_nxt = ~paused;
    end
  end
`else
  // Pause follows the debounced switch level
  always_comb begin
    w_paused_nxt = r_deb[IDX_PS];
  end
`endif

  // Registered mode and pause outputs; reset shows the all-on home pattern
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd    <= 1'b0;
      rev    <= 1'b0;
      home   <= 1'b1;
      paused <= 1'b0;
    end else begin
      fwd    <= w_fwd_nxt;
      rev    <= w_rev_nxt;
      home   <= w_home_nxt;
      paused <= w_paused_nxt;
    end
  end

  // Prescaler and period counter; a mode change restarts the period and suppresses step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pcnt <= '0;
      r_qcnt <= '0;
      step   <= 1'b0;
    end else if (w_mode_chg) begin
      r_pcnt <= '0;
      r_qcnt <= '0;
      step   <= 1'b0;
    end else begin
      step <= 1'b0;
      if (w_run) begin
        r_pcnt <= w_tick ? '0 : r_pcnt + PCNT_W'(1);
      end
      if (w_tick) begin
        if (r_qcnt >= max) begin
          r_qcnt <= '0;
          step   <= 1'b1;
        end else begin
          r_qcnt <= r_qcnt + MAX_W'(1);
        end
      end
    end
  end

endmodule
